// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the responder memory and the lane decoder:
//   htrans_e       - HTRANS encodings
//   HSIZE_*        - legal HSIZE encodings (byte / half / word)
//   HRESP_*        - single-bit AHB-Lite response encodings
//   slave_state_e  - data-phase state of the responder
// -----------------------------------------------------------------------------
package ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'd0,
      HT_BUSY   = 2'd1,
      HT_NONSEQ = 2'd2,
      HT_SEQ    = 2'd3
   } htrans_e;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_e;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// -----------------------------------------------------------------------------
// ahb_slave_mem_if
// AHB-Lite bus bundle between a master-side environment and ahb_slave_mem.
//   master modport : drives select, address-phase controls, write data, HREADY
//                    and the error-inject line; receives rdata/readyout/resp
//   slave  modport : the mirror image, used by the responder
// -----------------------------------------------------------------------------
interface ahb_slave_mem_if;

   logic        h_sel_0;
   logic [31:0] h_addr;
   logic [1:0]  h_trans;
   logic        h_write;
   logic [2:0]  h_size;
   logic [2:0]  h_burst;
   logic [3:0]  h_prot;
   logic [31:0] h_wdata;
   logic        h_ready;
   logic        apb_slverr;
   logic [31:0] h_rdata;
   logic        h_ready_out;
   logic        h_resp;

   modport master (
      output h_sel_0, h_addr, h_trans, h_write, h_size, h_burst, h_prot,
             h_wdata, h_ready, apb_slverr,
      input  h_rdata, h_ready_out, h_resp
   );

   modport slave (
      input  h_sel_0, h_addr, h_trans, h_write, h_size, h_burst, h_prot,
             h_wdata, h_ready, apb_slverr,
      output h_rdata, h_ready_out, h_resp
   );

endinterface

// File: rtl/ahb_byte_lane_dec.sv
// -----------------------------------------------------------------------------
// ahb_byte_lane_dec
// Combinational little-endian byte-lane decoder.
//   size     in  HSIZE of the transfer
//   addr_lo  in  byte address bits [1:0]
//   strobe   out one bit per byte lane of the 32-bit data bus
//   misalign out half on an odd address, or word not on a 4-byte boundary
// Sizes above a word give an empty strobe; the caller flags them separately.
// -----------------------------------------------------------------------------
module ahb_byte_lane_dec
   import ahb_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] strobe,
   output logic       misalign
);

   always_comb begin
      strobe   = 4'b0000;
      misalign = 1'b0;
      case (size)
         HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
         HSIZE_HALF: begin
            strobe   = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
         end
         HSIZE_WORD: begin
            strobe   = 4'b1111;
            misalign = |addr_lo;
         end
         default: strobe = 4'b0000;
      endcase
   end

endmodule

// File: rtl/ahb_slave_mem.sv
// -----------------------------------------------------------------------------
// ahb_slave_mem
// AHB-Lite responder backed by a DEPTH x 32-bit word memory at BASE_ADDR.
// Gives zero- or WAIT_STATES-wait OKAY data phases and a two-cycle ERROR
// response for out-of-range, illegal-size, misaligned or error-injected beats.
//   h_clk      in  bus clock, all logic on posedge
//   h_reset_n  in  synchronous active-low reset
//   bus        slave modport of ahb_slave_mem_if (address/data phase signals,
//              HREADY in, HREADYOUT / HRESP / HRDATA out)
// -----------------------------------------------------------------------------
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic           h_clk,
   input  logic           h_reset_n,
   ahb_slave_mem_if.slave bus
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);
   localparam logic [2:0]  WS   = 3'(WAIT_STATES);

   slave_state_e  state;
   logic [2:0]    wait_cnt;
   logic          ready_q;
   logic          resp_q;
   logic [31:0]   rdata_q;

   // Address-phase information held for the data phase.
   logic [AW-1:0] idx_p1;
   logic [3:0]    strb_p1;
   logic          write_p1;

   // A word reads as zero until first written since reset, so the storage
   // array itself never needs a reset sweep.
   logic [DEPTH-1:0] word_vld;
   logic [31:0]      mem [DEPTH];

   logic [31:0]   offset;
   logic [AW-1:0] idx_p0;
   logic [3:0]    strb_p0;
   logic          misalign_p0;
   logic          err_p0;
   logic          accept;
   logic          commit;
   logic [AW-1:0] rd_idx;
   logic [31:0]   cur_word;
   logic [31:0]   wr_word;
   logic [31:0]   rd_word;
   logic          unused_bus;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      return res;
   endfunction

   ahb_byte_lane_dec u_lane_dec (
      .size     (bus.h_size),
      .addr_lo  (bus.h_addr[1:0]),
      .strobe   (strb_p0),
      .misalign (misalign_p0)
   );

   // Modulo-2^32 offset: addresses below the base wrap high and fail the range test.
   assign offset = bus.h_addr - BASE_ADDR;
   assign idx_p0 = offset[AW+1:2];
   assign err_p0 = (offset >= SPAN) | (bus.h_size > HSIZE_WORD) |
                   misalign_p0 | bus.apb_slverr;

   // ready_q keeps the responder deaf while it holds the bus in WAIT/ERR1,
   // even if HREADY were driven high by another source.
   assign accept = bus.h_sel_0 & bus.h_ready & ready_q &
                   ((bus.h_trans == HT_NONSEQ) | (bus.h_trans == HT_SEQ));

   // DATA is only ever entered for a non-errored beat.
   assign commit = (state == ST_DATA) & write_p1;

   assign cur_word = word_vld[idx_p1] ? mem[idx_p1] : 32'h0;
   assign wr_word  = lane_merge(cur_word, bus.h_wdata, strb_p1);

   // Read word for the data phase being set up; a write completing this same
   // cycle to the same word is forwarded so back-to-back write/read agree.
   assign rd_idx = accept ? idx_p0 : idx_p1;
   always_comb begin
      rd_word = word_vld[rd_idx] ? mem[rd_idx] : 32'h0;
      if (commit && (rd_idx == idx_p1))
         rd_word = wr_word;
   end

   always_ff @(posedge h_clk) begin
      if (h_reset_n && commit)
         mem[idx_p1] <= wr_word;
   end

   always_ff @(posedge h_clk) begin
      if (!h_reset_n) begin
         state    <= ST_IDLE;
         wait_cnt <= 3'd0;
         ready_q  <= 1'b1;
         resp_q   <= HRESP_OKAY;
         rdata_q  <= 32'h0;
         idx_p1   <= '0;
         strb_p1  <= 4'b0000;
         write_p1 <= 1'b0;
         word_vld <= '0;
      end else begin
         if (commit)
            word_vld[idx_p1] <= 1'b1;

         case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
               if (accept) begin
                  idx_p1   <= idx_p0;
                  strb_p1  <= strb_p0;
                  write_p1 <= bus.h_write;
                  if (err_p0) begin
                     state   <= ST_ERR1;
                     ready_q <= 1'b0;
                     resp_q  <= HRESP_ERROR;
                     if (!bus.h_write)
                        rdata_q <= 32'h0;
                  end else if (WAIT_STATES > 0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WS;
                     ready_q  <= 1'b0;
                     resp_q   <= HRESP_OKAY;
                  end else begin
                     state   <= ST_DATA;
                     ready_q <= 1'b1;
                     resp_q  <= HRESP_OKAY;
                     if (!bus.h_write)
                        rdata_q <= rd_word;
                  end
               end else begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
                  resp_q  <= HRESP_OKAY;
               end
            end
            ST_WAIT: begin
               if (wait_cnt <= 3'd1) begin
                  state   <= ST_DATA;
                  ready_q <= 1'b1;
                  if (!write_p1)
                     rdata_q <= rd_word;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            ST_ERR1: begin
               state   <= ST_ERR2;
               ready_q <= 1'b1;
               resp_q  <= HRESP_ERROR;
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
               resp_q  <= HRESP_OKAY;
            end
         endcase
      end
   end

   assign bus.h_ready_out = ready_q;
   assign bus.h_resp      = resp_q;
   assign bus.h_rdata     = rdata_q;

   // Burst type, protection and the sub-word offset bits carry no meaning here.
   assign unused_bus = ^{bus.h_burst, bus.h_prot, offset[31:AW+2], offset[1:0]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_mem
// Two responders (0 and 3 wait states) share one pipelined AHB master; only
// the responder selected by 'act' sees h_sel_0. Expected responses come from a
// byte-addressed reference memory updated when each address phase is accepted,
// and a negedge monitor pops and compares them as data phases complete.
// -----------------------------------------------------------------------------
module tb_ahb_slave_mem;
   import ahb_pkg::*;

   localparam int unsigned DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int unsigned SPAN  = DEPTH * 4;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [31:0] wdata;
      logic        slverr;
   } item_t;

   typedef struct {
      logic        err;
      logic        wr;
      logic [31:0] rdata;
   } exp_t;

   logic        h_clk;
   logic        h_reset_n;
   logic        act;
   logic        h_sel_c;
   logic [1:0]  h_trans_c;
   logic [31:0] h_addr_c;
   logic        h_write_c;
   logic [2:0]  h_size_c;
   logic [2:0]  h_burst_c;
   logic [31:0] h_wdata_c;
   logic        slverr_c;
   logic        m_ready, m_resp;
   logic [31:0] m_rdata;

   int   n_checks = 0;
   int   n_err    = 0;
   item_t seq[$];
   exp_t  sbq[$];
   logic [7:0] mdl [2][SPAN];

   ahb_slave_mem_if b0 ();
   ahb_slave_mem_if b3 ();

   assign b0.h_sel_0 = h_sel_c & ~act;
   assign b3.h_sel_0 = h_sel_c & act;
   assign b0.h_addr = h_addr_c;     assign b3.h_addr = h_addr_c;
   assign b0.h_trans = h_trans_c;   assign b3.h_trans = h_trans_c;
   assign b0.h_write = h_write_c;   assign b3.h_write = h_write_c;
   assign b0.h_size = h_size_c;     assign b3.h_size = h_size_c;
   assign b0.h_burst = h_burst_c;   assign b3.h_burst = h_burst_c;
   assign b0.h_prot = 4'b0011;      assign b3.h_prot = 4'b0011;
   assign b0.h_wdata = h_wdata_c;   assign b3.h_wdata = h_wdata_c;
   assign b0.apb_slverr = slverr_c; assign b3.apb_slverr = slverr_c;
   assign b0.h_ready = b0.h_ready_out;
   assign b3.h_ready = b3.h_ready_out;

   assign m_ready = act ? b3.h_ready_out : b0.h_ready_out;
   assign m_resp  = act ? b3.h_resp      : b0.h_resp;
   assign m_rdata = act ? b3.h_rdata     : b0.h_rdata;

   ahb_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
      .h_clk(h_clk), .h_reset_n(h_reset_n), .bus(b0.slave));
   ahb_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
      .h_clk(h_clk), .h_reset_n(h_reset_n), .bus(b3.slave));

   initial h_clk = 1'b0;
   always #5 h_clk = ~h_clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic item_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic slverr, input logic [1:0] trans);
      item_t it;
      it.sel = 1'b1; it.trans = trans; it.wr = wr; it.addr = addr; it.size = size;
      it.burst = 3'b000; it.wdata = wdata; it.slverr = slverr;
      return it;
   endfunction

   function automatic item_t rnd_item();
      item_t it;
      int unsigned r;
      logic [31:0] off;
      it.wr    = 1'($urandom_range(0, 1));
      it.wdata = $urandom;
      it.burst = 3'($urandom_range(0, 7));
      it.sel   = ($urandom_range(0, 99) < 92);
      it.slverr = ($urandom_range(0, 99) < 5);
      r = $urandom_range(0, 99);
      it.size = (r < 5) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r = $urandom_range(0, 99);
      if (r < 8)       it.trans = HT_IDLE;
      else if (r < 12) it.trans = HT_BUSY;
      else if (r < 60) it.trans = HT_NONSEQ;
      else             it.trans = HT_SEQ;
      r = $urandom_range(0, 99);
      if (r < 6) begin
         it.addr = BASE - 32'($urandom_range(1, 16));
      end else if (r < 12) begin
         it.addr = BASE + SPAN + 32'($urandom_range(0, 64));
      end else begin
         off = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) != 0) begin
            if (it.size == 3'd1) off = off & ~32'd1;
            if (it.size == 3'd2) off = off & ~32'd3;
         end
         it.addr = BASE + off;
      end
      return it;
   endfunction

   // Reference: byte-addressed memory; a read sees every earlier accepted write.
   function automatic void issue(input item_t it);
      exp_t e;
      logic [31:0] off;
      int nb;
      off = it.addr - BASE;
      e.wr = it.wr;
      e.rdata = 32'h0;
      e.err = it.slverr || (off >= SPAN) || (it.size > 3'd2) ||
              (it.size == 3'd1 && off % 2 != 0) || (it.size == 3'd2 && off % 4 != 0);
      if (!e.err) begin
         nb = 1 << it.size;
         if (it.wr)
            for (int k = 0; k < nb; k++) mdl[act][off + k] = it.wdata[8*((off + k) % 4) +: 8];
         else
            for (int k = 0; k < 4; k++) e.rdata[8*k +: 8] = mdl[act][(off / 4) * 4 + k];
      end
      sbq.push_back(e);
   endfunction

   function automatic void mdl_clear();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < SPAN; i++) mdl[b][i] = 8'h00;
   endfunction

   task automatic drive_addr(input item_t it, input logic v);
      h_sel_c   = v & it.sel;
      h_trans_c = v ? it.trans : HT_IDLE;
      h_addr_c  = it.addr;
      h_write_c = it.wr;
      h_size_c  = it.size;
      h_burst_c = it.burst;
      slverr_c  = v & it.slverr;
   endtask

   task automatic drive_idle();
      item_t it;
      it = mk(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, HT_IDLE);
      drive_addr(it, 1'b0);
   endtask

   // Pipelined master: the address phase is held until HREADY, then the
   // accepted beat's write data is driven in its data phase.
   task automatic run_items();
      item_t a;
      logic  a_v;
      logic  rdy;
      int    guard;
      a_v = 1'b0;
      guard = 0;
      a = mk(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, HT_IDLE);
      if (seq.size() > 0) begin a = seq.pop_front(); a_v = 1'b1; end
      drive_addr(a, a_v);
      while (a_v) begin
         @(negedge h_clk);
         rdy = m_ready;
         @(posedge h_clk);
         #1;
         guard++;
         if (guard > 5000) begin
            n_checks++; n_err++;
            $display("FAIL driver_timeout: %0d items left, required 0", seq.size());
            seq.delete();
            break;
         end
         if (rdy) begin
            if (a.sel && a.trans[1]) begin
               issue(a);
               h_wdata_c = a.wdata;
            end
            if (seq.size() > 0) a = seq.pop_front();
            else a_v = 1'b0;
            drive_addr(a, a_v);
         end
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      drive_idle();
      while ((sbq.size() != 0 || dp_active) && g < 100) begin
         @(posedge h_clk); #1; g++;
      end
      if (g >= 100) begin
         n_checks++; n_err++;
         $display("FAIL drain_timeout: %0d responses pending, required 0", sbq.size());
         sbq.delete();
      end
      @(posedge h_clk); #1;
   endtask

   task automatic sweep();
      for (int w = 0; w < 16; w++)
         seq.push_back(mk(1'b0, BASE + 32'(4 * w), 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      run_items();
      drain();
   endtask

   // Monitor: tracks the outstanding data phase and checks it when HREADYOUT rises.
   logic dp_active = 1'b0;
   int   waits = 0;
   logic low_or = 1'b0;
   logic low_and = 1'b1;
   exp_t mon_e;

   always @(negedge h_clk) begin
      if (!h_reset_n) begin
         dp_active = 1'b0; waits = 0; low_or = 1'b0; low_and = 1'b1;
      end else begin
         if (dp_active) begin
            if (!m_ready) begin
               waits++;
               low_or  = low_or | m_resp;
               low_and = low_and & m_resp;
            end else begin
               if (sbq.size() == 0) begin
                  n_checks++; n_err++;
                  $display("FAIL sb_underflow: data phase completed with no expected response");
               end else begin
                  mon_e = sbq.pop_front();
                  chk("resp", 32'(m_resp), 32'(mon_e.err));
                  chk("wait_cycles", 32'(waits), mon_e.err ? 32'd1 : (act ? 32'd3 : 32'd0));
                  chk("wait_resp", mon_e.err ? 32'(low_and) : 32'(low_or), mon_e.err ? 32'd1 : 32'd0);
                  if (!mon_e.wr) chk("rdata", m_rdata, mon_e.rdata);
               end
               waits = 0; low_or = 1'b0; low_and = 1'b1;
            end
         end
         if (m_ready) dp_active = h_sel_c & h_trans_c[1];
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached before completion");
      $fatal(1, "watchdog");
   end

   initial begin
      item_t it;
      act = 1'b0;
      h_reset_n = 1'b0;
      h_wdata_c = 32'h0;
      drive_idle();
      mdl_clear();
      repeat (3) @(posedge h_clk);
      #1;
      chk("reset_ready0", 32'(b0.h_ready_out), 32'd1);
      chk("reset_resp0",  32'(b0.h_resp), 32'd0);
      chk("reset_rdata0", b0.h_rdata, 32'h0);
      chk("reset_ready3", 32'(b3.h_ready_out), 32'd1);
      chk("reset_resp3",  32'(b3.h_resp), 32'd0);
      chk("reset_rdata3", b3.h_rdata, 32'h0);
      h_reset_n = 1'b1;
      @(posedge h_clk); #1;

      // Zero-wait responder: directed cases.
      seq.push_back(mk(1'b1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE + 32'h10, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b1, BASE + 32'h21, 3'd0, 32'h0000_1100, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b1, BASE + 32'h23, 3'd0, 32'h2200_0000, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE + 32'h20, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b1, BASE + 32'(SPAN), 3'd2, 32'h5555_AAAA, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b1, BASE + 32'h3, 3'd1, 32'hFFFF_FFFF, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b1, BASE + 32'h10, 3'd2, 32'h1234_5678, 1'b1, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE + 32'h10, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE + 32'h10, 3'd2, 32'h0, 1'b1, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE - 32'h4, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE + 32'h20, 3'd3, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE + 32'h22, 3'd1, 32'h0, 1'b0, HT_NONSEQ));
      run_items();
      drain();

      repeat (200) seq.push_back(rnd_item());
      run_items();
      drain();
      sweep();

      // Three-wait responder: INCR4 read burst over freshly written words.
      act = 1'b1;
      @(posedge h_clk); #1;
      for (int i = 0; i < 4; i++)
         seq.push_back(mk(1'b1, BASE + 32'h30 + 32'(4 * i), 3'd2, 32'hC0DE_0000 + 32'(i), 1'b0, HT_NONSEQ));
      for (int i = 0; i < 4; i++) begin
         it = mk(1'b0, BASE + 32'h30 + 32'(4 * i), 3'd2, 32'h0, 1'b0, (i == 0) ? HT_NONSEQ : HT_SEQ);
         it.burst = 3'b011;
         seq.push_back(it);
      end
      seq.push_back(mk(1'b1, BASE + 32'(SPAN), 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE + 32'h30, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      run_items();
      drain();

      repeat (200) seq.push_back(rnd_item());
      run_items();
      drain();
      sweep();

      // Reset while a write sits in its wait states: it must never land.
      it = mk(1'b1, BASE + 32'h40, 3'd2, 32'hA5A5_A5A5, 1'b0, HT_NONSEQ);
      drive_addr(it, 1'b1);
      @(posedge h_clk); #1;
      drive_idle();
      h_wdata_c = 32'hA5A5_A5A5;
      chk("rst_in_wait_ready", 32'(m_ready), 32'd0);
      h_reset_n = 1'b0;
      @(posedge h_clk); #1;
      h_reset_n = 1'b1;
      chk("rst_in_wait_ready_after", 32'(m_ready), 32'd1);
      chk("rst_in_wait_resp_after", 32'(m_resp), 32'd0);
      chk("rst_in_wait_rdata_after", m_rdata, 32'h0);
      mdl_clear();
      @(posedge h_clk); #1;
      seq.push_back(mk(1'b0, BASE + 32'h40, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      seq.push_back(mk(1'b0, BASE + 32'h30, 3'd2, 32'h0, 1'b0, HT_NONSEQ));
      run_items();
      drain();

      chk("sb_leftover", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite responder (slave) that terminates transfers driven by the AHB master agent and backs them with a word-addressed memory. It sits on select line h_sel_0 of the PLIC DV environment's AHB interface. It provides the OKAY and ERROR data-phase responses and programmable wait states, so the master driver and monitor can be closed-loop tested without the DUT. Byte, halfword and word writes are little-endian; reads always return the full 32-bit word.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 4..4096
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4
WAIT_STATES, 0, h_ready_out low cycles inserted in each OKAY data phase, 0..7

Ports:
h_clk  input  1  bus clock; all logic on posedge
h_reset_n  input  1  synchronous active-low reset
h_sel_0  input  1  slave select, address phase
h_addr  input  32  byte address, address phase
h_trans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
h_write  input  1  1=write, address phase
h_size  input  3  0=byte, 1=half, 2=word; >2 is illegal
h_burst  input  3  accepted but ignored; each beat is decoded independently
h_prot  input  4  ignored
h_wdata  input  32  write data, data phase
h_ready  input  1  bus HREADY; an address phase is accepted only when high
apb_slverr  input  1  error inject, sampled with the accepted address phase
h_rdata  output  32  read data, valid when h_ready_out=1 in a read data phase
h_ready_out  output  1  slave HREADYOUT
h_resp  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (h_reset_n=0 at a posedge): h_ready_out=1, h_resp=0, h_rdata=0, FSM to IDLE, all memory words cleared to 0. Any pending data phase is abandoned and no write commits.
- Accept condition: h_sel_0 & h_ready & h_trans[1]. On accept, register the address, write flag, size and an error flag.
- Error flag is set by any of the following:
  - offset (h_addr-BASE_ADDR) >= DEPTH*4;
  - h_size>2;
  - misalignment (half with addr[0]=1; word with addr[1:0]!=0);
  - apb_slverr=1.
- IDLE/BUSY transfers, or h_sel_0=0 with h_ready=1: no accept. The next cycle gives h_ready_out=1, h_resp=0 (zero-wait OKAY).
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: counter counts WAIT_STATES down with h_ready_out=0, h_resp=0.
  - DATA: h_ready_out=1, h_resp=0; the transfer completes this cycle.
  - ERR1: h_ready_out=0, h_resp=1.
  - ERR2: h_ready_out=1, h_resp=1.
- Transitions:
  - Accept with error goes to ERR1, then ERR2. Error takes precedence and no wait states are inserted.
  - Accept without error goes to WAIT if WAIT_STATES>0, otherwise to DATA.
  - WAIT goes to DATA when the counter reaches 1.
  - From DATA or ERR2, a new accept in the same cycle goes back-to-back into the next data phase; otherwise the FSM returns to IDLE.
- Write commit: on the data-phase cycle with h_ready_out=1 and the transfer non-errored, h_wdata lanes selected by size and addr[1:0] are written to mem[offset>>2].
  - byte: lane = addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
  - An errored write never commits.
- Read data:
  - h_rdata = mem[word] during the read data phase, and must reflect every write whose data phase completed before this read's data phase (covers write-then-read of the same address back-to-back; forward if h_rdata is registered).
  - h_rdata holds its last value outside read data phases.
  - Errored reads drive h_rdata=0.
- Accept ignored: during WAIT and ERR1, h_ready=0, so no new address phase is taken.
- Address wrap: offsets are computed modulo 2^32. An address below BASE_ADDR wraps to a large offset and returns ERROR.

Decomposition:
- ahb_pkg holds:
  - htrans_e enum (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE_BYTE/HALF/WORD constants;
  - HRESP_OKAY/HRESP_ERROR;
  - slave_state_e (IDLE, WAIT, DATA, ERR1, ERR2).
- One sub-module, ahb_byte_lane_dec: combinational. Maps (h_size, addr[1:0]) to a 4-bit lane strobe plus a misalign flag. It is reused later by the AHB-to-APB bridge.

Test Plan:
- Reset, then NONSEQ word write 0xDEADBEEF to BASE+0x10, then read BASE+0x10 back-to-back, WAIT_STATES=0 -> both data phases have h_ready_out=1, h_resp=0; read returns 0xDEADBEEF.
- Byte writes 0x11, 0x22 to BASE+0x21 and BASE+0x23 over a word of 0 -> word read of BASE+0x20 returns 0x22001100.
- WAIT_STATES=3, INCR4 SEQ word reads -> each beat has exactly 3 cycles of h_ready_out=0; beats are returned in order with no beat dropped or duplicated.
- Word write to BASE+DEPTH*4 -> ERR1 (ready 0, resp 1) then ERR2 (ready 1, resp 1); a subsequent read of word 0 returns unchanged data.
- Halfword write at BASE+0x3, and separately a word write with apb_slverr=1 -> both get two-cycle ERROR; memory is unchanged.
- h_reset_n low during a WAIT phase of a write of 0xA5A5A5A5 -> next cycle h_ready_out=1, h_resp=0; the address reads back 0.
